// File: rtl/mult_pkg.sv
// Shared types for the repeated-addition multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

endpackage

// File: rtl/mult_down_cntr.sv
// Loadable down-counter holding the remaining iteration count.
// It saturates at zero, so it never wraps.
module mult_down_cntr #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             dec,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ld) begin
      cnt_d = din;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign dout = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/rep_add_mult_seq.sv
// Sequential multiplier by repeated addition with start/busy/done handshake.
// Define OPERAND_SWAP_EN to iterate over the smaller operand (shorter latency).
module rep_add_mult_seq
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  mult_state_t          state_q, state_d;
  logic [2*WIDTH-1:0]   a_q, a_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;

  logic                 cnt_ld, cnt_dec, cnt_zero;
  logic [WIDTH-1:0]     cnt_din, cnt_dout;
  logic [WIDTH-1:0]     mcand, mplier;

`ifdef OPERAND_SWAP_EN
  // The smaller operand becomes the loop count; the product is unchanged.
  always_comb begin
    if (a_in < b_in) begin
      mcand  = b_in;
      mplier = a_in;
    end else begin
      mcand  = a_in;
      mplier = b_in;
    end
  end
`else
  assign mcand  = a_in;
  assign mplier = b_in;
`endif

  mult_down_cntr #(.WIDTH(WIDTH)) u_cntr (
    .clk  (clk),
    .rst  (rst),
    .ld   (cnt_ld),
    .dec  (cnt_dec),
    .din  (cnt_din),
    .dout (cnt_dout),
    .zero (cnt_zero)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    p_d     = p_q;
    prod_d  = prod_q;
    cnt_ld  = 1'b0;
    cnt_dec = 1'b0;
    cnt_din = mplier;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_ld  = 1'b1;
          a_d     = (2*WIDTH)'(mcand);
          p_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // product is loaded on the way into DONE so it is valid with the pulse.
        if (cnt_zero) begin
          prod_d  = p_q;
          state_d = DONE;
        end else begin
          p_d     = p_q + a_q;
          cnt_dec = 1'b1;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      p_q     <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      p_q     <= p_d;
      prod_q  <= prod_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign product = prod_q;

  logic unused_cnt;
  assign unused_cnt = ^cnt_dout;

endmodule

// File: tb/tb_rep_add_mult_seq.sv
// Randomised self-checking bench for rep_add_mult_seq at WIDTH=8 and WIDTH=16.
module tb_rep_add_mult_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start8, start16;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;
  logic        busy8, done8, busy16, done16;
  logic [15:0] prod8;
  logic [31:0] prod16;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  rep_add_mult_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a_in(a8), .b_in(b8),
    .busy(busy8), .done(done8), .product(prod8)
  );

  rep_add_mult_seq #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .a_in(a16), .b_in(b16),
    .busy(busy16), .done(done16), .product(prod16)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference iteration count: how many additions the unit must perform.
  function automatic longint unsigned iters(input longint unsigned a, input longint unsigned b);
`ifdef OPERAND_SWAP_EN
    return (a < b) ? a : b;
`else
    return b;
`endif
  endfunction

  task automatic sample(input int sel, output logic d, output logic bs, output logic [31:0] pr);
    if (sel == 8) begin
      d = done8; bs = busy8; pr = {16'h0, prod8};
    end else begin
      d = done16; bs = busy16; pr = prod16;
    end
  endtask

  task automatic drive(input int sel, input logic s, input logic [31:0] a, input logic [31:0] b);
    if (sel == 8) begin
      start8 = s; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      start16 = s; a16 = a[15:0]; b16 = b[15:0];
    end
  endtask

  // Counts edges to the done pulse, then checks the pulse ends and product holds.
  task automatic finish_op(input int sel, input logic [31:0] exp_prod,
                           input longint unsigned exp_lat, input int pre_edges,
                           input string tag);
    logic d, bs;
    logic [31:0] pr;
    int k = 0;
    int busy_low = 0;
    d = 1'b0;
    while (!d && k < 70000) begin
      @(posedge clk); #1;
      k++;
      sample(sel, d, bs, pr);
      if (!bs) busy_low++;
    end
    check({tag, "_lat"}, 64'(pre_edges + k), 64'(exp_lat));
    check({tag, "_prod"}, 64'(pr), 64'(exp_prod));
    check({tag, "_busy"}, 64'(busy_low), 64'd0);
    @(posedge clk); #1;
    sample(sel, d, bs, pr);
    check({tag, "_pulse"}, {62'd0, d, bs}, 64'd0);
    check({tag, "_hold"}, 64'(pr), 64'(exp_prod));
  endtask

  task automatic do_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                       input string tag);
    longint unsigned exp;
    exp = longint'(a) * longint'(b);
    @(negedge clk);
    drive(sel, 1'b1, a, b);
    @(posedge clk); #1;
    drive(sel, 1'b0, $urandom, $urandom);
    finish_op(sel, exp[31:0], iters(a, b) + 1, 0, tag);
  endtask

  initial begin
    logic d, bs;
    logic [31:0] pr;
    int dcount;
    rst = 1'b1;
    drive(8, 1'b0, 0, 0);
    drive(16, 1'b0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    sample(8, d, bs, pr);
    check("rst8", {d, bs, pr}, 34'd0);
    sample(16, d, bs, pr);
    check("rst16", {d, bs, pr}, 34'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op(16, 3, 5, "t1_3x5");
    do_op(16, 7, 0, "t2_7x0");
    do_op(16, 0, 9, "t2_0x9");

    // start re-pulsed mid-RUN with new operands must be ignored
    @(negedge clk);
    drive(16, 1'b1, 3, 5);
    @(posedge clk); #1;
    drive(16, 1'b0, 0, 0);
    @(posedge clk); #1;
    @(negedge clk);
    drive(16, 1'b1, 9, 9);
    @(posedge clk); #1;
    drive(16, 1'b0, 0, 0);
    finish_op(16, 15, iters(3, 5) + 1, 2, "t4_restart");
    do_op(16, 4, 4, "t4_b2b");

    // reset mid-RUN
    @(negedge clk);
    drive(16, 1'b1, 3, 5);
    @(posedge clk); #1;
    drive(16, 1'b0, 0, 0);
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    sample(16, d, bs, pr);
    check("t5_rst", {d, bs, pr}, 34'd0);
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    repeat (10) begin
      @(posedge clk); #1;
      sample(16, d, bs, pr);
      if (d || bs) dcount++;
    end
    check("t5_nodone", 64'(dcount), 64'd0);
    do_op(16, 2, 2, "t5_2x2");

    fork
      begin
        do_op(16, 32'hFFFF, 32'hFFFF, "t3_max");
        for (int i = 0; i < 200; i++) begin
          logic [31:0] ra, rb;
          ra = $urandom_range(0, 1) ? $urandom_range(0, 65535) : $urandom_range(0, 63);
          rb = $urandom_range(0, 63);
          if ($urandom_range(0, 1)) do_op(16, ra, rb, "r16");
          else do_op(16, rb, ra, "r16");
        end
      end
      begin
        for (int j = 0; j < 200; j++) begin
          do_op(8, $urandom_range(0, 255), $urandom_range(0, 255), "r8");
        end
        do_op(8, 255, 255, "r8_max");
      end
    join

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
